cam_init_seq: RTL and testbench

//  Sequences the camera sensor register-init table held in the Gowin_pROM (512 x 16b words,
//  {reg_addr[15:8], reg_data[7:0]}) into single-register SCCB/I2C writes. Sits between the pROM
//  and the I2C master; runs once after reset (and again on start), supports in-table delays,

---
 rtl/cam_init_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_cam_init_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_init_seq.sv
// cam_init_seq
//   Walks the camera sensor init table held in the pROM. Each 16-bit word is
//   {reg_addr, reg_data}. A normal word becomes one SCCB/I2C register write.
//   A word whose reg_addr is DLY_ADDR is a pause of reg_data milliseconds and
//   is never sent to the sensor.
//   The sequence runs once after reset and again on each accepted start pulse.
//   A write that is NACKed or times out is retried up to MAX_RETRY more times.
//   After that the sequence stops with init_fail set.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   start                       restart pulse, accepted only in IDLE
//   rom_ce/oce/reset/ad/dout    pROM read port
//   i2c_req/reg/dat             write request (level) and its payload
//   i2c_done/nack               write result pulses from the I2C master
//   busy                        sequence in progress
//   init_done/init_fail         result flags, held until the next start
//   fail_idx                    index of the entry that exhausted its retries
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | finished, waiting for start
// PWR_WAIT | sensor power-up settle time before the first fetch
// FETCH    | one-cycle pROM read of entry idx
// ROMWAIT  | wait out the pROM latency, then latch the word
// DECODE   | route to DELAY/NEXT for a delay word, else WRITE
// WRITE    | i2c_req held until done, nack or timeout
// DELAY    | in-table pause of reg_data ms
// NEXT     | advance idx or finish
// DONE     | one cycle with init_done set, then IDLE
// FAIL     | one cycle with init_fail set, then IDLE
module cam_init_seq #(
  parameter int unsigned NUM_ENTRIES  = 512,
  parameter int unsigned ROM_LAT      = 1,
  parameter logic [7:0]  DLY_ADDR     = 8'hFF,
  parameter int unsigned TICKS_PER_MS = 27000,
  parameter int unsigned PWR_WAIT_MS  = 20,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned ACK_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rom_ce,
  output logic        rom_oce,
  output logic        rom_reset,
  output logic [8:0]  rom_ad,
  input  logic [15:0] rom_dout,
  output logic        i2c_req,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_dat,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        init_done,
  output logic        init_fail,
  output logic [8:0]  fail_idx
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICKS_PER_MS - 1);
  localparam logic [7:0]    PWR_LOAD  = 8'(PWR_WAIT_MS);
  localparam logic [15:0]   TO_LOAD   = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0]   LAT_LOAD  = 16'(ROM_LAT - 1);
  localparam logic [8:0]    LAST_IDX  = 9'(NUM_ENTRIES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_FETCH, S_ROMWAIT, S_DECODE,
    S_WRITE, S_DELAY, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    idx_q, idx_d;
  logic [15:0]   ent_q, ent_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    ms_q, ms_d;
  logic [15:0]   to_q, to_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [8:0]    fail_idx_q, fail_idx_d;
  logic          wait_end;

  // The ms/tick pair counts down together. The last cycle of the wait is the
  // final tick of the final millisecond, so a load of N ms spends exactly
  // N*TICKS_PER_MS cycles in the state. A load of 0 leaves at once.
  assign wait_end = (ms_q == 8'd0) || ((ms_q == 8'd1) && (tick_q == '0));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ent_d      = ent_q;
    retry_d    = retry_q;
    tick_d     = tick_q;
    ms_d       = ms_q;
    to_d       = to_q;
    done_d     = done_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PWR_WAIT;
          idx_d      = '0;
          retry_d    = '0;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          fail_idx_d = '0;
          ms_d       = PWR_LOAD;
          tick_d     = TICK_LOAD;
        end
      end
      S_PWR_WAIT, S_DELAY: begin
        if (wait_end) begin
          state_d = (state_q == S_PWR_WAIT) ? S_FETCH : S_NEXT;
        end else if (tick_q == '0) begin
          tick_d = TICK_LOAD;
          ms_d   = ms_q - 8'd1;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_ROMWAIT;
        to_d    = LAT_LOAD;
      end
      S_ROMWAIT: begin
        if (to_q == 16'd0) begin
          ent_d   = rom_dout;
          state_d = S_DECODE;
        end else begin
          to_d = to_q - 16'd1;
        end
      end
      S_DECODE: begin
        if (ent_q[15:8] == DLY_ADDR) begin
          if (ent_q[7:0] == 8'd0) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_DELAY;
            ms_d    = ent_q[7:0];
            tick_d  = TICK_LOAD;
          end
        end else begin
          state_d = S_WRITE;
          to_d    = TO_LOAD;
        end
      end
      S_WRITE: begin
        // done has priority over a coincident nack. A retry goes back through
        // DECODE, which holds i2c_req low for one cycle between attempts.
        if (i2c_done) begin
          retry_d = '0;
          state_d = S_NEXT;
        end else if (i2c_nack || (to_q == 16'd0)) begin
          if (retry_q == RETRY_MAX) begin
            state_d    = S_FAIL;
            fail_d     = 1'b1;
            fail_idx_d = idx_q;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = S_DECODE;
          end
        end else begin
          to_d = to_q - 16'd1;
        end
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE, S_FAIL: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_PWR_WAIT;
      idx_q      <= '0;
      ent_q      <= '0;
      retry_q    <= '0;
      tick_q     <= TICK_LOAD;
      ms_q       <= PWR_LOAD;
      to_q       <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ent_q      <= ent_d;
      retry_q    <= retry_d;
      tick_q     <= tick_d;
      ms_q       <= ms_d;
      to_q       <= to_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign rom_ce    = (state_q == S_FETCH);
  assign rom_oce   = 1'b1;
  assign rom_reset = ~rst_n;
  assign rom_ad    = idx_q;
  assign i2c_req   = (state_q == S_WRITE);
  assign i2c_reg   = ent_q[15:8];
  assign i2c_dat   = ent_q[7:0];
  assign busy      = (state_q != S_IDLE);
  assign init_done = done_q;
  assign init_fail = fail_q;
  assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// tb_cam_init_seq
//   Directed bench for cam_init_seq, built with a 4-entry table, 4 ticks per
//   ms, 2 ms power-up wait, 2 retries and a 16-cycle ack timeout. A pROM model
//   and an I2C responder surround the DUT. The responder answers 3 cycles after
//   the request goes high. It can stay silent for one register, or NACK a set
//   number of times before it ACKs.
module tb_cam_init_seq;

  localparam int ACK_DLY = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rom_ce, rom_oce, rom_reset;
  logic [8:0]  rom_ad;
  logic [15:0] rom_dout;
  logic        i2c_req;
  logic [7:0]  i2c_reg, i2c_dat;
  logic        i2c_done, i2c_nack;
  logic        busy, init_done, init_fail;
  logic [8:0]  fail_idx;

  int total = 0;
  int bad   = 0;

  logic [15:0] rom [4];
  logic [7:0]  silent_reg = 8'hAA;
  logic [7:0]  nack_reg   = 8'hAA;
  int          nack_cfg   = 0;

  logic [15:0] wr_log [$];
  int          wr_start [$];
  int          wr_end [$];
  int          cyc = 0;
  bit          prev_req;
  int          req_cyc = 0;
  bit          answered;
  int          nacks_given = 0;

  cam_init_seq #(
    .NUM_ENTRIES(4), .ROM_LAT(1), .DLY_ADDR(8'hFF), .TICKS_PER_MS(4),
    .PWR_WAIT_MS(2), .MAX_RETRY(2), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
    .rom_ad(rom_ad), .rom_dout(rom_dout),
    .i2c_req(i2c_req), .i2c_reg(i2c_reg), .i2c_dat(i2c_dat),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .busy(busy), .init_done(init_done), .init_fail(init_fail),
    .fail_idx(fail_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rom_ce) rom_dout <= rom[rom_ad[1:0]];
  end

  // Log each write request, then respond to the DUT. Inputs change on the
  // falling edge, so the DUT samples them at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (i2c_req && !prev_req) begin
      wr_log.push_back({i2c_reg, i2c_dat});
      wr_start.push_back(cyc);
    end
    if (!i2c_req && prev_req) wr_end.push_back(cyc);
    prev_req = i2c_req;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (i2c_req) begin
      if (!answered) begin
        req_cyc++;
        if (i2c_reg != silent_reg && req_cyc == ACK_DLY) begin
          answered = 1'b1;
          if (i2c_reg == nack_reg && nacks_given < nack_cfg) begin
            i2c_nack = 1'b1;
            nacks_given++;
          end else begin
            i2c_done = 1'b1;
            nacks_given = 0;
          end
        end
      end
    end else begin
      req_cyc  = 0;
      answered = 1'b0;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // sel 0: busy low, 1: i2c_req high, 2: init_done high
  task automatic wait_for(input int sel, input int lim);
    total++;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((sel == 0 && busy === 1'b0) || (sel == 1 && i2c_req === 1'b1) ||
          (sel == 2 && init_done === 1'b1)) return;
    end
    bad++;
    $display("FAIL wait_%0d: got timeout after %0d cycles, expected condition reached", sel, lim);
  endtask

  task automatic check_writes(input string name, input int base, input logic [15:0] exp_w [$]);
    total++;
    if (wr_log.size() - base != exp_w.size()) begin
      bad++;
      $display("FAIL %s_count: got %0d writes expected %0d", name, wr_log.size() - base, exp_w.size());
    end else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        total++;
        if (wr_log[base + i] !== exp_w[i]) begin
          bad++;
          $display("FAIL %s_w%0d: got %h expected %h", name, i, wr_log[base + i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b expected 1", busy); end
    total++; if (rom_ce !== 1'b0) begin bad++; $display("FAIL rst_rom_ce: got %b expected 0", rom_ce); end
    total++; if (rom_ad !== 9'd0) begin bad++; $display("FAIL rst_rom_ad: got %0d expected 0", rom_ad); end
    total++; if (i2c_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b expected 0", i2c_req); end
    total++; if ({i2c_reg, i2c_dat} !== 16'h0000) begin bad++; $display("FAIL rst_regdat: got %h expected 0000", {i2c_reg, i2c_dat}); end
    total++; if ({init_done, init_fail} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b expected 00", {init_done, init_fail}); end
    total++; if (fail_idx !== 9'd0) begin bad++; $display("FAIL rst_fail_idx: got %0d expected 0", fail_idx); end
    total++; if ({rom_oce, rom_reset} !== 2'b11) begin bad++; $display("FAIL rst_rom_ctl: got %b expected 11", {rom_oce, rom_reset}); end
  endtask

  task automatic test_powerup();
    int k = 0;
    logic [8:0] ad = 9'h1FF;
    bit req_seen = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (i2c_req === 1'b1) req_seen = 1'b1;
      if (rom_ce === 1'b1) begin
        k  = i;
        ad = rom_ad;
      end
    end
    total++; if (k != 8) begin bad++; $display("FAIL pwr_first_fetch: got cycle %0d expected 8", k); end
    total++; if (ad !== 9'd0) begin bad++; $display("FAIL pwr_first_ad: got %0d expected 0", ad); end
    total++; if (req_seen) begin bad++; $display("FAIL pwr_req_early: got req=1 expected 0"); end
  endtask

  task automatic test_basic();
    int base = wr_log.size();
    int gap;
    logic [15:0] exp_w [$] = '{16'h0304, 16'h04E2, 16'h0900};
    wait_for(0, 300);
    check_writes("basic", base, exp_w);
    gap = (wr_start.size() > base + 2) ? wr_start[base + 2] - wr_end[base + 1] : 0;
    total++; if (gap < 8) begin bad++; $display("FAIL basic_delay_gap: got %0d expected >=8", gap); end
    total++; if ({init_done, init_fail, busy} !== 3'b100) begin bad++; $display("FAIL basic_flags: got %b expected 100", {init_done, init_fail, busy}); end
  endtask

  task automatic test_nack_retry();
    int base = wr_log.size();
    logic [15:0] exp_w [$] = '{16'h0304, 16'h04E2, 16'h04E2, 16'h04E2, 16'h0900};
    nack_reg = 8'h04;
    nack_cfg = 2;
    pulse_start();
    wait_for(0, 400);
    check_writes("nack", base, exp_w);
    total++; if ({init_done, init_fail} !== 2'b10) begin bad++; $display("FAIL nack_flags: got %b expected 10", {init_done, init_fail}); end
    nack_reg = 8'hAA;
    nack_cfg = 0;
  endtask

  task automatic test_timeout();
    int base = wr_log.size();
    logic [15:0] exp_w [$] = '{16'h0304, 16'h04E2, 16'h0511, 16'h0511, 16'h0511};
    rom[2]     = 16'h0511;
    silent_reg = 8'h05;
    pulse_start();
    wait_for(0, 400);
    check_writes("tmo", base, exp_w);
    for (int i = 2; i < 5; i++) begin
      total++;
      if (wr_end.size() <= base + i || wr_end[base + i] - wr_start[base + i] != 16) begin
        bad++;
        $display("FAIL tmo_len%0d: got %0d cycles expected 16", i,
                 (wr_end.size() > base + i) ? wr_end[base + i] - wr_start[base + i] : -1);
      end
    end
    total++; if ({init_done, init_fail} !== 2'b01) begin bad++; $display("FAIL tmo_flags: got %b expected 01", {init_done, init_fail}); end
    total++; if (fail_idx !== 9'd2) begin bad++; $display("FAIL tmo_fail_idx: got %0d expected 2", fail_idx); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [15:0] exp_w [$] = '{16'h0304, 16'h04E2, 16'h0900};
    rom[2]     = 16'hFF02;
    silent_reg = 8'hAA;
    base = wr_log.size();
    pulse_start();
    total++; if ({init_fail, busy} !== 2'b01) begin bad++; $display("FAIL b2b_restart: got fail,busy=%b expected 01", {init_fail, busy}); end
    wait_for(1, 100);
    pulse_start();
    wait_for(2, 300);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_start_in_done: got busy=%b expected 0", busy); end
    check_writes("b2b", base, exp_w);
    total++; if ({init_done, init_fail} !== 2'b10) begin bad++; $display("FAIL b2b_flags: got %b expected 10", {init_done, init_fail}); end
  endtask

  task automatic test_reset_mid_write();
    int base;
    logic [15:0] exp_w [$] = '{16'h0304, 16'h04E2, 16'h0900};
    pulse_start();
    wait_for(1, 100);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (i2c_req !== 1'b0) begin bad++; $display("FAIL rmw_req: got %b expected 0", i2c_req); end
    total++; if ({busy, init_done} !== 2'b10) begin bad++; $display("FAIL rmw_state: got busy,done=%b expected 10", {busy, init_done}); end
    total++; if (rom_ad !== 9'd0) begin bad++; $display("FAIL rmw_idx: got %0d expected 0", rom_ad); end
    @(negedge clk) rst_n = 1'b1;
    base = wr_log.size();
    wait_for(0, 300);
    check_writes("rmw", base, exp_w);
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL rmw_done: got %b expected 1", init_done); end
  endtask

  initial begin
    rom[0] = 16'h0304;
    rom[1] = 16'h04E2;
    rom[2] = 16'hFF02;
    rom[3] = 16'h0900;
    test_reset();
    test_powerup();
    test_basic();
    test_nack_retry();
    test_timeout();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
